udp_rx_pkt_fifo: RTL

- Sits directly downstream of the UDP/IP/MAC receive path: consumes the per-byte UDP payload stream (in_valid / in_data / in_length) produced by the Ethernet UDP test top.
- Buffers whole packets in a circular byte RAM with a per-packet length descriptor FIFO.
- Commits a packet only once it has been fully received; drops packets that do not fit.
- Replays committed packets to an application consumer over a valid/ready byte stream with a last flag.

---
 rtl/udp_rx_pkt_fifo.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/udp_rx_pkt_fifo.sv
// ---------------------------------------------------------------------------
// udp_rx_pkt_fifo
//
// Packet buffer that sits behind the UDP receive path. Incoming payload bytes
// are written into a circular byte RAM. A packet becomes visible to the reader
// only after its last byte has arrived and its byte count matches the declared
// length. Each committed packet has a (length, start address) descriptor in a
// small FIFO. Packets that are too long, that do not fit, that find the
// descriptor FIFO full, or whose byte count does not match their length are
// dropped and counted.
//
// Ports
//   rgmii_clk   : clock, rising edge
//   rstn        : synchronous reset, active low
//   in_valid    : payload byte strobe, contiguous for one packet
//   in_data     : payload byte
//   in_length   : declared payload length, stable while in_valid is high
//   out_valid   : out_data holds a packet byte
//   out_data    : packet byte
//   out_last    : final byte of the packet
//   out_length  : length of the packet being streamed
//   out_ready   : consumer accepts the byte on out_valid & out_ready
//   pkt_avail   : committed packets not yet fully read (includes the one streaming)
//   drop_count  : dropped packets, saturating
// ---------------------------------------------------------------------------
module udp_rx_pkt_fifo #(
    parameter int ADDR_W  = 11,
    parameter int DESC_W  = 3,
    parameter int MAX_LEN = 1472
) (
    input  logic            rgmii_clk,
    input  logic            rstn,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    input  logic [15:0]     in_length,
    output logic            out_valid,
    output logic [7:0]      out_data,
    output logic            out_last,
    output logic [15:0]     out_length,
    input  logic            out_ready,
    output logic [DESC_W:0] pkt_avail,
    output logic [15:0]     drop_count
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam int              NDESC     = 1 << DESC_W;
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [DESC_W:0] NDESC_L   = (DESC_W+1)'(NDESC);
    localparam logic [15:0]     MAX_LEN_L = 16'(MAX_LEN);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Storage (no reset: contents are don't-care after reset)
    logic [7:0]        ram           [DEPTH];
    logic [15:0]       desc_len_mem  [NDESC];
    logic [ADDR_W-1:0] desc_addr_mem [NDESC];

    // -----------------------------------------------------------------------
    // Write side
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} wstate_t;

    wstate_t           w_state, w_next;
    logic              prev_valid;
    logic              pkt_start;
    logic              accept_ok;
    logic              wr_en, commit, rewind, drop;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_tmp;
    logic [15:0]       byte_cnt, wr_len;
    logic [DESC_W-1:0] desc_wr_ptr, desc_rd_ptr;
    logic [DESC_W:0]   desc_cnt;
    logic [ADDR_W:0]   used, free_bytes;

    // Read-side control shared with the counters below
    logic              pop, rel;

    assign pkt_start  = in_valid & ~prev_valid;
    // Only one packet is ever in flight and it is decided at its start, so
    // at the admission point 'used' holds exactly the committed unread bytes.
    assign free_bytes = DEPTH_L - used;
    // The descriptor slot of a streaming packet stays reserved until its last
    // byte is read, so fullness is judged on pkt_avail, not on desc_cnt.
    assign accept_ok  = (in_length != 16'd0) && (in_length <= MAX_LEN_L) &&
                        (16'(free_bytes) >= in_length) && (pkt_avail != NDESC_L);

    always_ff @(posedge rgmii_clk) begin
        if (!rstn) w_state <= W_IDLE;
        else       w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        wr_en  = 1'b0;
        commit = 1'b0;
        rewind = 1'b0;
        drop   = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (pkt_start) begin
                    if (accept_ok) begin
                        w_next = W_RECV;
                        wr_en  = 1'b1;
                    end else begin
                        w_next = W_DROP;
                    end
                end
            end
            W_RECV: begin
                if (!in_valid) begin
                    if (byte_cnt == wr_len) begin
                        commit = 1'b1;
                    end else begin
                        rewind = 1'b1;
                        drop   = 1'b1;
                    end
                    w_next = W_IDLE;
                end else if (byte_cnt == wr_len) begin
                    // One byte more than declared: abandon the packet now so
                    // nothing is written past its reserved space.
                    w_next = W_DROP;
                end else begin
                    wr_en = 1'b1;
                end
            end
            W_DROP: begin
                if (!in_valid) begin
                    rewind = 1'b1;
                    drop   = 1'b1;
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge rgmii_clk) begin
        if (!rstn) begin
            prev_valid  <= 1'b0;
            wr_ptr      <= '0;
            wr_ptr_tmp  <= '0;
            byte_cnt    <= '0;
            wr_len      <= '0;
            desc_wr_ptr <= '0;
            drop_count  <= '0;
        end else begin
            prev_valid <= in_valid;
            if (w_state == W_IDLE && pkt_start)
                wr_len <= in_length;
            if (wr_en) begin
                wr_ptr_tmp <= wr_ptr_tmp + 1'b1;
                byte_cnt   <= (w_state == W_IDLE) ? 16'd1 : byte_cnt + 16'd1;
            end
            if (commit) begin
                wr_ptr      <= wr_ptr_tmp;
                desc_wr_ptr <= desc_wr_ptr + 1'b1;
            end
            if (rewind)
                wr_ptr_tmp <= wr_ptr;
            if (drop)
                drop_count <= sat_inc16(drop_count);
        end
    end

    always_ff @(posedge rgmii_clk) begin
        if (wr_en)
            ram[wr_ptr_tmp] <= in_data;
        if (commit) begin
            desc_len_mem[desc_wr_ptr]  <= wr_len;
            desc_addr_mem[desc_wr_ptr] <= wr_ptr;
        end
    end

    // Occupancy: commit and release may land in the same cycle; apply both.
    always_ff @(posedge rgmii_clk) begin
        if (!rstn) begin
            desc_cnt  <= '0;
            pkt_avail <= '0;
            used      <= '0;
        end else begin
            desc_cnt  <= desc_cnt  + (DESC_W+1)'(commit) - (DESC_W+1)'(pop);
            pkt_avail <= pkt_avail + (DESC_W+1)'(commit) - (DESC_W+1)'(rel);
            used      <= used + (commit ? wr_len[ADDR_W:0]     : '0)
                              - (rel    ? out_length[ADDR_W:0] : '0);
        end
    end

    // -----------------------------------------------------------------------
    // Read side
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {R_IDLE, R_LOAD, R_STREAM} rstate_t;

    rstate_t           r_state, r_next;
    logic              fetch, load, advance;
    logic [ADDR_W-1:0] rd_ptr, fetch_addr;
    logic [7:0]        pf_data_p1;
    logic [15:0]       rd_left;

    // rd_ptr always points at the next byte to prefetch.
    assign fetch_addr = pop ? desc_addr_mem[desc_rd_ptr] : rd_ptr;

    always_ff @(posedge rgmii_clk) begin
        if (!rstn) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    always_comb begin
        r_next  = r_state;
        pop     = 1'b0;
        fetch   = 1'b0;
        load    = 1'b0;
        advance = 1'b0;
        rel     = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (desc_cnt != '0) begin
                    pop    = 1'b1;
                    fetch  = 1'b1;
                    r_next = R_LOAD;
                end
            end
            R_LOAD: begin
                load   = 1'b1;
                fetch  = 1'b1;
                r_next = R_STREAM;
            end
            R_STREAM: begin
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        rel    = 1'b1;
                        r_next = R_IDLE;
                    end else begin
                        advance = 1'b1;
                        fetch   = 1'b1;
                    end
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Stage p1: registered RAM read into the prefetch register. It always
    // holds the byte following out_data, so a handshake can present the next
    // byte on the very next cycle.
    always_ff @(posedge rgmii_clk) begin
        if (fetch)
            pf_data_p1 <= ram[fetch_addr];
    end

    // Stage p2: output register, held while the consumer stalls.
    always_ff @(posedge rgmii_clk) begin
        if (!rstn) begin
            rd_ptr      <= '0;
            desc_rd_ptr <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= '0;
            out_length  <= '0;
            rd_left     <= '0;
        end else begin
            if (fetch)
                rd_ptr <= fetch_addr + 1'b1;
            if (pop) begin
                desc_rd_ptr <= desc_rd_ptr + 1'b1;
                out_length  <= desc_len_mem[desc_rd_ptr];
            end
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= pf_data_p1;
                out_last  <= (out_length == 16'd1);
                rd_left   <= out_length;
            end
            if (advance) begin
                out_data <= pf_data_p1;
                out_last <= (rd_left == 16'd2);
                rd_left  <= rd_left - 16'd1;
            end
            if (rel) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule
